// File: rtl/midterm_store_ctrl.sv
// Store/load controller: circular buffer of {unit,value} readings filled on store edges and
// drained on load edges, with the last popped value shown as two digits on a muxed 7-seg display.
module midterm_store_ctrl #(
    parameter int DEPTH     = 4,
    parameter int REFRESH_W = 16
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [3:0]                 d_in,
    input  logic [1:0]                 t_in,
    input  logic                       ld_in,
    input  logic                       st_in,
    output logic [3:0]                 rd_data,
    output logic [1:0]                 rd_unit,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf,
    output logic [3:0]                 an,
    output logic [6:0]                 seg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        DIG_ONES,
        DIG_TENS
    } digit_e;

    logic                 st_q, ld_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [3:0]           rd_data_q, rd_data_d;
    logic [1:0]           rd_unit_q, rd_unit_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    digit_e               digit_q, digit_d;
    logic [5:0]           mem_q [DEPTH];
    logic [5:0]           mem_d [DEPTH];

    logic                 push_req, pop_req, push_ok, pop_ok;
    logic                 full_w, empty_w;
    logic                 tens_w;
    logic [3:0]           ones_w, dig_val;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Buffer control: a pop while full frees the slot the simultaneous push needs,
    // but a pop while empty is rejected so data never bypasses the buffer.
    always_comb begin
        push_req   = st_in & ~st_q;
        pop_req    = ld_in & ~ld_q;
        empty_w    = (count_q == '0);
        full_w     = (count_q == CNT_W'(DEPTH));
        pop_ok     = pop_req & ~empty_w;
        push_ok    = push_req & (~full_w | pop_ok);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q | (push_req & ~push_ok);
        unf_d      = unf_q | (pop_req & ~pop_ok);
        rd_data_d  = rd_data_q;
        rd_unit_d  = rd_unit_q;
        rd_valid_d = pop_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = {t_in, d_in};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            {rd_unit_d, rd_data_d} = mem_q[rd_ptr_q];
            rd_ptr_d               = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        tens_w    = (rd_data_q >= 4'd10);
        ones_w    = tens_w ? (rd_data_q - 4'd10) : rd_data_q;
        refresh_d = refresh_q + REFRESH_W'(1);
        digit_d   = digit_q;
        an        = 4'b1110;
        dig_val   = ones_w;

        if (refresh_q == '1) begin
            digit_d = (digit_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
        case (digit_q)
            DIG_TENS: begin
                an      = 4'b1101;
                dig_val = {3'b000, tens_w};
            end
            default: begin
                an      = 4'b1110;
                dig_val = ones_w;
            end
        endcase
        seg = seg7(dig_val);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            st_q       <= 1'b0;
            ld_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_unit_q  <= '0;
            rd_valid_q <= 1'b0;
            refresh_q  <= '0;
            digit_q    <= DIG_ONES;
        end else begin
            st_q       <= st_in;
            ld_q       <= ld_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_data_q  <= rd_data_d;
            rd_unit_q  <= rd_unit_d;
            rd_valid_q <= rd_valid_d;
            refresh_q  <= refresh_d;
            digit_q    <= digit_d;
        end
    end

    // Storage has no reset; entries are only observable after being written.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_unit  = rd_unit_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_midterm_store_ctrl.sv
// Scoreboard bench for midterm_store_ctrl: loads push expected {unit,value} into a queue,
// a negedge monitor checks every rd_valid pulse against it; status/display checked directly.
module tb_midterm_store_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] d_in;
    logic [1:0] t_in;
    logic       ld_in;
    logic       st_in;
    logic [3:0] rd_data;
    logic [1:0] rd_unit;
    logic       rd_valid;
    logic [2:0] count;
    logic       full, empty, ovf, unf;
    logic [3:0] an;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    midterm_store_ctrl #(.DEPTH(4), .REFRESH_W(2)) dut (
        .clk(clk), .clr(clr), .d_in(d_in), .t_in(t_in), .ld_in(ld_in), .st_in(st_in),
        .rd_data(rd_data), .rd_unit(rd_unit), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf), .an(an), .seg(seg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_pulse: got unexpected rd_valid with unit=%0h data=%0h", rd_unit, rd_data);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({rd_unit, rd_data} !== e) begin
                    failures++;
                    $display("FAIL rd_entry: got unit=%0h data=%0h expected unit=%0h data=%0h",
                             rd_unit, rd_data, e[5:4], e[3:0]);
                end
            end
        end
    end

    task automatic push(input logic [3:0] v, input logic [1:0] u);
        d_in  = v;
        t_in  = u;
        st_in = 1'b1;
        @(negedge clk);
        st_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop(input logic expect_data, input logic [3:0] v, input logic [1:0] u);
        if (expect_data) exp_q.push_back({u, v});
        ld_in = 1'b1;
        @(negedge clk);
        ld_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pushpop(input logic [3:0] pv, input logic [1:0] pu,
                           input logic expect_data, input logic [3:0] v, input logic [1:0] u);
        if (expect_data) exp_q.push_back({u, v});
        d_in  = pv;
        t_in  = pu;
        st_in = 1'b1;
        ld_in = 1'b1;
        @(negedge clk);
        st_in = 1'b0;
        ld_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_an, exp_an;
        logic       seen;

        clr   = 1'b0;
        st_in = 1'b0;
        ld_in = 1'b0;
        d_in  = '0;
        t_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_unf",   32'(unf),   32'd0);
        chk("rst_rdv",   32'(rd_valid), 32'd0);
        chk("rst_rdd",   32'(rd_data), 32'd0);
        chk("rst_an",    32'(an),    32'b1110);
        chk("rst_seg",   32'(seg),   32'b1000000);
        clr = 1'b1;
        @(negedge clk);

        // Basic ordering
        push(4'd3, 2'b01);
        push(4'd12, 2'b01);
        push(4'd7, 2'b01);
        chk("fifo3_count", 32'(count), 32'd3);
        pop(1'b1, 4'd3, 2'b01);
        pop(1'b1, 4'd12, 2'b01);
        pop(1'b1, 4'd7, 2'b01);
        chk("fifo3_count_end", 32'(count), 32'd0);
        chk("fifo3_empty", 32'(empty), 32'd1);

        // Overflow with pointers starting mid-buffer
        push(4'd9, 2'd0);
        push(4'd14, 2'd1);
        push(4'd0, 2'd2);
        push(4'd15, 2'd3);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf0", 32'(ovf), 32'd0);
        push(4'd5, 2'd1);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_full", 32'(full), 32'd1);
        pop(1'b1, 4'd9, 2'd0);
        pop(1'b1, 4'd14, 2'd1);
        pop(1'b1, 4'd0, 2'd2);
        pop(1'b1, 4'd15, 2'd3);
        chk("drain_empty", 32'(empty), 32'd1);

        // Underflow
        pop(1'b0, 4'd0, 2'd0);
        chk("unf_set", 32'(unf), 32'd1);
        chk("unf_hold", 32'(rd_data), 32'd15);
        pushpop(4'd6, 2'd2, 1'b0, 4'd0, 2'd0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_unf", 32'(unf), 32'd1);
        pop(1'b1, 4'd6, 2'd2);

        // Held store level
        d_in  = 4'd11;
        t_in  = 2'd3;
        st_in = 1'b1;
        repeat (10) @(negedge clk);
        st_in = 1'b0;
        @(negedge clk);
        chk("hold_count", 32'(count), 32'd1);

        // Simultaneous push/pop while non-empty
        pushpop(4'd4, 2'd0, 1'b1, 4'd11, 2'd3);
        chk("pp_ne_count", 32'(count), 32'd1);
        pop(1'b1, 4'd4, 2'd0);

        // Display of 12
        push(4'd12, 2'd1);
        pop(1'b1, 4'd12, 2'd1);
        prev_an = an;
        seen    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (an !== prev_an) begin
                seen = 1'b1;
                break;
            end
        end
        chk("disp_toggle_seen", 32'(seen), 32'd1);
        exp_an = an;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                chk("disp_an", 32'(an), 32'(exp_an));
                chk("disp_seg", 32'(seg), (exp_an == 4'b1110) ? 32'b0100100 : 32'b1111001);
                @(negedge clk);
            end
            exp_an = (exp_an == 4'b1110) ? 4'b1101 : 4'b1110;
        end

        // Simultaneous push/pop while full, from a clean state
        do_reset();
        push(4'd1, 2'd0);
        push(4'd2, 2'd1);
        push(4'd3, 2'd2);
        push(4'd8, 2'd3);
        pushpop(4'd10, 2'd1, 1'b1, 4'd1, 2'd0);
        chk("pp_full_count", 32'(count), 32'd4);
        chk("pp_full_ovf", 32'(ovf), 32'd0);
        pop(1'b1, 4'd2, 2'd1);
        pop(1'b1, 4'd3, 2'd2);
        pop(1'b1, 4'd8, 2'd3);
        pop(1'b1, 4'd10, 2'd1);

        // Reset mid-operation with 3 entries and ovf set
        push(4'd1, 2'd0);
        push(4'd2, 2'd0);
        push(4'd3, 2'd0);
        push(4'd4, 2'd0);
        push(4'd5, 2'd0);
        pop(1'b1, 4'd1, 2'd0);
        chk("pre_clr_count", 32'(count), 32'd3);
        chk("pre_clr_ovf", 32'(ovf), 32'd1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_an", 32'(an), 32'b1110);
        chk("clr_seg", 32'(seg), 32'b1000000);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
